// File: rtl/zx_mem_arbiter_if.sv
// Bus bundle for zx_mem_arbiter: CPU, video fetcher, loader DMA and RAM sides.
// slave is the arbiter's view; master is the clients/RAM view.
interface zx_mem_arbiter_if;
    logic        cpu_clk;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_o;
    logic        cpu_we;
    logic [7:0]  cpu_i;

    logic        vid_req;
    logic [12:0] vid_a;
    logic [7:0]  vid_q;
    logic        vid_valid;
    logic        vid_overrun;

    logic        ld_req;
    logic [15:0] ld_a;
    logic [7:0]  ld_d;
    logic        ld_we;
    logic        ld_rom_wr_en;
    logic        ld_ack;
    logic [7:0]  ld_q;

    logic [15:0] mem_a;
    logic [7:0]  mem_d;
    logic        mem_we;
    logic [7:0]  mem_q;

    logic        prot_fault;

    modport slave (
        input  cpu_clk, cpu_a, cpu_o, cpu_we,
        input  vid_req, vid_a,
        input  ld_req, ld_a, ld_d, ld_we, ld_rom_wr_en,
        input  mem_q,
        output cpu_i, vid_q, vid_valid, vid_overrun,
        output ld_ack, ld_q,
        output mem_a, mem_d, mem_we, prot_fault
    );

    modport master (
        output cpu_clk, cpu_a, cpu_o, cpu_we,
        output vid_req, vid_a,
        output ld_req, ld_a, ld_d, ld_we, ld_rom_wr_en,
        output mem_q,
        input  cpu_i, vid_q, vid_valid, vid_overrun,
        input  ld_ack, ld_q,
        input  mem_a, mem_d, mem_we, prot_fault
    );
endinterface

// File: rtl/zx_mem_arbiter.sv
// Single-port RAM arbiter for Z80, video fetcher and loader DMA in the memory clock domain.
// One grant per cycle; a 2-stage tag pipeline routes registered read data back to its owner.
module zx_mem_arbiter #(
    parameter logic [15:0] ROM_TOP    = 16'h4000,
    parameter logic [15:0] VID_BASE   = 16'h4000,
    parameter int unsigned STARVE_MAX = 8
) (
    input logic             clk,
    input logic             reset_n,
    zx_mem_arbiter_if.slave bus
);
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {TagNone, TagCpu, TagVid, TagLd} tag_t;

    logic [1:0]    sync_q;
    logic          sync_dly_q;
    logic          cpu_edge;
    logic          cpu_pend_q;
    logic [15:0]   cpu_a_q;
    logic [7:0]    cpu_d_q;
    logic          cpu_we_q;
    logic          vid_pend_q;
    logic [12:0]   vid_a_q;
    logic [SW-1:0] starve_q;
    tag_t          tag0_q, tag1_q;
    logic          rd0_q, rd1_q;

    logic [15:0]   mem_a_q;
    logic [7:0]    mem_d_q;
    logic          mem_we_q;
    logic          prot_q;
    logic [7:0]    cpu_i_q, vid_q_q, ld_q_q;
    logic          vid_valid_q, vid_ovr_q, ld_ack_q;

    tag_t          gnt;
    logic          ld_busy, ld_elig, ld_starved;
    logic          iss_we, iss_fault, iss_rd;
    logic [15:0]   iss_a;
    logic [7:0]    iss_d;
    tag_t          iss_tag;

    assign cpu_edge   = sync_q[1] & ~sync_dly_q;
    // A loader transfer is in flight until its ack cycle; the ack cycle itself may re-grant.
    assign ld_busy    = (tag0_q == TagLd) || (tag1_q == TagLd);
    assign ld_elig    = bus.ld_req & ~ld_busy;
    assign ld_starved = (starve_q == SW'(STARVE_MAX));

    always_comb begin
        gnt = TagNone;
        if (cpu_pend_q) begin
            gnt = TagCpu;
        end else if (ld_elig && ld_starved) begin
            gnt = TagLd;
        end else if (vid_pend_q) begin
            gnt = TagVid;
        end else if (ld_elig) begin
            gnt = TagLd;
        end
    end

    always_comb begin
        iss_we    = 1'b0;
        iss_fault = 1'b0;
        iss_rd    = 1'b0;
        iss_a     = mem_a_q;
        iss_d     = mem_d_q;
        iss_tag   = TagNone;
        unique case (gnt)
            TagCpu: begin
                if (cpu_we_q && (cpu_a_q < ROM_TOP)) begin
                    iss_fault = 1'b1;
                end else begin
                    iss_we  = cpu_we_q;
                    iss_a   = cpu_a_q;
                    iss_d   = cpu_d_q;
                    iss_tag = cpu_we_q ? TagNone : TagCpu;
                end
            end
            TagVid: begin
                iss_a   = VID_BASE + {3'b000, vid_a_q};
                iss_tag = TagVid;
            end
            TagLd: begin
                // Suppressed loader writes still carry a tag so the ack arrives on time.
                iss_tag = TagLd;
                iss_rd  = ~bus.ld_we;
                if (bus.ld_we && (bus.ld_a < ROM_TOP) && !bus.ld_rom_wr_en) begin
                    iss_fault = 1'b1;
                end else begin
                    iss_we = bus.ld_we;
                    iss_a  = bus.ld_a;
                    iss_d  = bus.ld_d;
                end
            end
            default: ;
        endcase
    end

    // Sync chain resets high so a cpu_clk already high at release is not an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q     <= 2'b11;
            sync_dly_q <= 1'b1;
            cpu_pend_q <= 1'b0;
            cpu_a_q    <= 16'h0000;
            cpu_d_q    <= 8'h00;
            cpu_we_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus.cpu_clk};
            sync_dly_q <= sync_q[1];
            if (cpu_edge) begin
                cpu_pend_q <= 1'b1;
                cpu_a_q    <= bus.cpu_a;
                cpu_d_q    <= bus.cpu_o;
                cpu_we_q   <= bus.cpu_we;
            end else if (gnt == TagCpu) begin
                cpu_pend_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_pend_q <= 1'b0;
            vid_a_q    <= 13'h0000;
            vid_ovr_q  <= 1'b0;
            starve_q   <= '0;
        end else begin
            vid_pend_q <= bus.vid_req | (vid_pend_q & (gnt != TagVid));
            vid_ovr_q  <= bus.vid_req & vid_pend_q & (gnt != TagVid);
            if (bus.vid_req) begin
                vid_a_q <= bus.vid_a;
            end
            if (gnt == TagLd) begin
                starve_q <= '0;
            end else if (ld_elig && !ld_starved) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_a_q     <= 16'h0000;
            mem_d_q     <= 8'h00;
            mem_we_q    <= 1'b0;
            prot_q      <= 1'b0;
            tag0_q      <= TagNone;
            tag1_q      <= TagNone;
            rd0_q       <= 1'b0;
            rd1_q       <= 1'b0;
            cpu_i_q     <= 8'hFF;
            vid_q_q     <= 8'h00;
            vid_valid_q <= 1'b0;
            ld_ack_q    <= 1'b0;
            ld_q_q      <= 8'h00;
        end else begin
            mem_a_q     <= iss_a;
            mem_d_q     <= iss_d;
            mem_we_q    <= iss_we;
            prot_q      <= iss_fault;
            tag0_q      <= iss_tag;
            rd0_q       <= iss_rd;
            tag1_q      <= tag0_q;
            rd1_q       <= rd0_q;
            vid_valid_q <= (tag1_q == TagVid);
            ld_ack_q    <= (tag1_q == TagLd);
            if (tag1_q == TagCpu) begin
                cpu_i_q <= bus.mem_q;
            end
            if (tag1_q == TagVid) begin
                vid_q_q <= bus.mem_q;
            end
            if ((tag1_q == TagLd) && rd1_q) begin
                ld_q_q <= bus.mem_q;
            end
        end
    end

    assign bus.mem_a       = mem_a_q;
    assign bus.mem_d       = mem_d_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.prot_fault  = prot_q;
    assign bus.cpu_i       = cpu_i_q;
    assign bus.vid_q       = vid_q_q;
    assign bus.vid_valid   = vid_valid_q;
    assign bus.vid_overrun = vid_ovr_q;
    assign bus.ld_ack      = ld_ack_q;
    assign bus.ld_q        = ld_q_q;
endmodule

// File: tb/tb_zx_mem_arbiter.sv
// Bench for zx_mem_arbiter: directed scenarios plus concurrent random CPU/video/loader traffic,
// scored against a reference memory image with per-port expectation queues.
module tb_zx_mem_arbiter;
    localparam logic [15:0] ROM_TOP    = 16'h4000;
    localparam logic [15:0] VID_BASE   = 16'h4000;
    localparam int          STARVE_MAX = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    zx_mem_arbiter_if bus ();

    zx_mem_arbiter #(
        .ROM_TOP    (ROM_TOP),
        .VID_BASE   (VID_BASE),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rd;
        logic [7:0] data;
    } ld_exp_t;

    logic [7:0] ref_mem [65536];
    logic [7:0] ram [65536];
    logic [7:0] cpu_exp [$];
    logic [7:0] vid_exp [$];
    ld_exp_t    ld_exp [$];
    ld_exp_t    ld_e;
    logic [7:0] cpu_last;

    int n_checks = 0, n_pass = 0;
    int exp_faults = 0, seen_faults = 0, exp_rom_wr = 0, seen_rom_wr = 0;
    int exp_vids = 0, vid_seen = 0, ovr_seen = 0, exp_acks = 0, ack_seen = 0;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 32'h5000) return 8'hA5;
        if (i == 0) return 8'h12;
        return 8'((i * 37) ^ (i >> 7) ^ 8'h5A);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // RAM model: 1-cycle registered read.
    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = init_byte(i);
        bus.mem_q = 8'h00;
        forever begin
            @(posedge clk);
            if (bus.mem_we) ram[bus.mem_a] <= bus.mem_d;
            bus.mem_q <= ram[bus.mem_a];
        end
    end

    // Monitor: pops expectations whenever the DUT presents an output.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.vid_valid) begin
                vid_seen++;
                if (vid_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL vid_spurious: vid_valid with no request, vid_q=%0h", bus.vid_q);
                end else begin
                    check("vid_data", 32'(bus.vid_q), 32'(vid_exp.pop_front()));
                end
            end
            if (bus.vid_overrun) ovr_seen++;
            if (bus.ld_ack) begin
                ack_seen++;
                if (ld_exp.size() == 0) begin
                    n_checks++;
                    $display("FAIL ld_spurious: ld_ack with no request, ld_q=%0h", bus.ld_q);
                end else begin
                    ld_e = ld_exp.pop_front();
                    if (ld_e.rd) check("ld_data", 32'(bus.ld_q), 32'(ld_e.data));
                end
            end
            if (bus.prot_fault) seen_faults++;
            if (bus.mem_we && (bus.mem_a < ROM_TOP)) seen_rom_wr++;
        end
    end

    // The CPU consumes read data at the falling cpu_clk edge of its cycle.
    always @(negedge bus.cpu_clk) begin
        if (reset_n && cpu_exp.size() != 0) check("cpu_i", 32'(bus.cpu_i), 32'(cpu_exp.pop_front()));
    end

    task automatic cpu_rise(input logic [15:0] a, input logic [7:0] d, input logic we);
        bus.cpu_a  = a;
        bus.cpu_o  = d;
        bus.cpu_we = we;
        if (we) begin
            if (a >= ROM_TOP) ref_mem[a] = d;
            else exp_faults++;
        end else begin
            cpu_last = ref_mem[a];
        end
        cpu_exp.push_back(cpu_last);
        bus.cpu_clk = 1'b1;
    endtask

    task automatic cpu_txn(input logic [15:0] a, input logic [7:0] d, input logic we);
        @(posedge clk); #1;
        cpu_rise(a, d, we);
        repeat (8) @(posedge clk);
        #1 bus.cpu_clk = 1'b0;
        repeat (8) @(posedge clk);
    endtask

    task automatic ld_txn(input logic [15:0] a, input logic [7:0] d, input logic we, input logic en);
        int w;
        @(posedge clk); #1;
        bus.ld_a         = a;
        bus.ld_d         = d;
        bus.ld_we        = we;
        bus.ld_rom_wr_en = en;
        if (we) begin
            if ((a < ROM_TOP) && !en) begin
                exp_faults++;
            end else begin
                ref_mem[a] = d;
                if (a < ROM_TOP) exp_rom_wr++;
            end
            ld_exp.push_back({1'b0, 8'h00});
        end else begin
            ld_exp.push_back({1'b1, ref_mem[a]});
        end
        exp_acks++;
        bus.ld_req = 1'b1;
        w = 0;
        do begin
            @(posedge clk); #1;
            w++;
        end while (!bus.ld_ack && w < 200);
        bus.ld_req = 1'b0;
        if (w >= 200) begin
            n_checks++;
            $display("FAIL ld_timeout: no ld_ack after %0d cycles for addr %0h", w, a);
        end
    endtask

    task automatic vid_txn(input logic [12:0] off);
        int w;
        @(posedge clk); #1;
        bus.vid_req = 1'b1;
        bus.vid_a   = off;
        vid_exp.push_back(ref_mem[VID_BASE + {3'b000, off}]);
        exp_vids++;
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
        w = 0;
        while (vid_exp.size() != 0 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) begin
            n_checks++;
            $display("FAIL vid_timeout: no vid_valid for offset %0h", off);
        end
    endtask

    initial begin
        int waited, mism;
        bus.cpu_clk = 1'b1;
        bus.cpu_a = 16'h2345; bus.cpu_o = 8'h00; bus.cpu_we = 1'b0;
        bus.vid_req = 1'b0; bus.vid_a = 13'h0000;
        bus.ld_req = 1'b0; bus.ld_a = 16'h0000; bus.ld_d = 8'h00;
        bus.ld_we = 1'b0; bus.ld_rom_wr_en = 1'b0;
        cpu_last = 8'hFF;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
        #1 reset_n = 1'b0;

        // Reset values, then release with cpu_clk already high.
        repeat (3) @(posedge clk); #1;
        check("rst_cpu_i", 32'(bus.cpu_i), 32'hFF);
        check("rst_mem_a", 32'(bus.mem_a), 32'h0);
        check("rst_flags", 32'({bus.mem_we, bus.prot_fault, bus.vid_valid, bus.vid_overrun,
                                bus.ld_ack}), 32'h0);
        check("rst_data", 32'({bus.mem_d, bus.vid_q, bus.ld_q}), 32'h0);
        reset_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("no_spurious_edge_cpu_i", 32'(bus.cpu_i), 32'hFF);
        check("no_spurious_edge_mem_a", 32'(bus.mem_a), 32'h0);
        bus.cpu_clk = 1'b0;
        repeat (8) @(posedge clk);

        // CPU read latency: mem_a at edge+2, cpu_i at edge+4.
        @(posedge clk); #1;
        cpu_rise(16'h5000, 8'h00, 1'b0);
        repeat (4) @(posedge clk); #1;
        check("cpu_rd_mem_a", 32'(bus.mem_a), 32'h5000);
        @(posedge clk); #1;
        check("cpu_rd_not_yet", 32'(bus.cpu_i), 32'hFF);
        @(posedge clk); #1;
        check("cpu_rd_data", 32'(bus.cpu_i), 32'hA5);
        repeat (2) @(posedge clk); #1;
        bus.cpu_clk = 1'b0;
        repeat (8) @(posedge clk);

        // Protected CPU write.
        cpu_txn(16'h0100, 8'h3C, 1'b1);
        check("cpu_rom_wr_fault", 32'(seen_faults), 32'(exp_faults));
        check("cpu_rom_wr_no_we", 32'(seen_rom_wr), 32'h0);

        // Video request on the CPU edge cycle: CPU first, video the cycle after.
        @(posedge clk); #1;
        cpu_rise(16'h2000, 8'h00, 1'b0);
        repeat (2) @(posedge clk); #1;
        bus.vid_req = 1'b1;
        bus.vid_a   = 13'h0010;
        vid_exp.push_back(ref_mem[16'h4010]);
        exp_vids++;
        @(posedge clk); #1;
        bus.vid_req = 1'b0;
        @(posedge clk); #1;
        check("edge_vid_cpu_first", 32'(bus.mem_a), 32'h2000);
        @(posedge clk); #1;
        check("edge_vid_second", 32'(bus.mem_a), 32'h4010);
        repeat (3) @(posedge clk); #1;
        bus.cpu_clk = 1'b0;
        repeat (8) @(posedge clk);
        check("edge_vid_once", 32'(vid_seen), 32'(exp_vids));

        // Continuous video with loader waiting: loader wins after STARVE_MAX waits.
        @(posedge clk); #1;
        bus.vid_a   = 13'h0123;
        bus.vid_req = 1'b1;
        @(posedge clk); #1;
        bus.ld_a = 16'hC123; bus.ld_we = 1'b0; bus.ld_rom_wr_en = 1'b0; bus.ld_req = 1'b1;
        ld_exp.push_back({1'b1, ref_mem[16'hC123]});
        exp_acks++;
        waited = 0;
        while (!bus.ld_ack && waited < 60) begin
            vid_exp.push_back(ref_mem[16'h4123]);
            exp_vids++;
            @(posedge clk); #1;
            waited++;
        end
        bus.ld_req = 1'b0;
        check("ld_starve_latency", 32'(waited), 32'(STARVE_MAX + 3));
        repeat (4) begin
            vid_exp.push_back(ref_mem[16'h4123]);
            exp_vids++;
            @(posedge clk); #1;
        end
        bus.vid_req = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("vid_overrun_once", 32'(ovr_seen), 32'h1);
        check("ld_ack_once", 32'(ack_seen), 32'(exp_acks));

        // Loader ROM writes with and without permission, then read back.
        ld_txn(16'h0000, 8'hF3, 1'b1, 1'b1);
        check("ld_rom_wr_en_write", 32'(seen_rom_wr), 32'(exp_rom_wr));
        ld_txn(16'h0000, 8'h77, 1'b1, 1'b0);
        check("ld_rom_wr_blocked_fault", 32'(seen_faults), 32'(exp_faults));
        ld_txn(16'h0000, 8'h00, 1'b0, 1'b0);

        // Concurrent random traffic on disjoint write regions.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    int unsigned r;
                    r = $urandom_range(0, 3);
                    if (r == 0) cpu_txn(16'($urandom_range(0, 16'h3FFF)), 8'($urandom), 1'b1);
                    else if (r == 1) cpu_txn(16'h8000 | 16'($urandom_range(0, 16'h3FFF)),
                                             8'($urandom), 1'b1);
                    else cpu_txn(16'($urandom_range(16'h2000, 16'hBFFF)), 8'h00, 1'b0);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [15:0] a;
                    a = $urandom_range(0, 1) ? (16'hC000 | 16'($urandom_range(0, 16'h3FFF)))
                                             : 16'($urandom_range(0, 16'h1FFF));
                    ld_txn(a, 8'($urandom), 1'($urandom), 1'($urandom));
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                end
            end
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 4)) @(posedge clk);
                    vid_txn(13'($urandom));
                end
            end
        join

        waited = 0;
        while ((cpu_exp.size() + vid_exp.size() + ld_exp.size()) != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("queues_drained", 32'(cpu_exp.size() + vid_exp.size() + ld_exp.size()), 32'h0);
        check("vid_count", 32'(vid_seen), 32'(exp_vids));
        check("vid_overrun_total", 32'(ovr_seen), 32'h1);
        check("ld_ack_count", 32'(ack_seen), 32'(exp_acks));
        check("prot_fault_count", 32'(seen_faults), 32'(exp_faults));
        check("rom_write_count", 32'(seen_rom_wr), 32'(exp_rom_wr));
        mism = 0;
        for (int i = 0; i < 65536; i++) if (ram[i] !== ref_mem[i]) mism++;
        check("ram_image_mismatches", 32'(mism), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
